// File: rtl/mem_arb_pkg.sv
// Shared types and lane helpers for the RAM port arbiter.
// Optional starvation guard is enabled with MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } ls_size_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  // Byte-lane write enables for an access of the given size at addr[1:0].
  function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << addr_lo;
      SZ_HALF: s = 4'b0011 << addr_lo;
      SZ_WORD: s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Size code 3 is illegal and reported the same way as a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = addr_lo[0];
      SZ_WORD: m = (addr_lo != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core (fetch + load/store), the arbiter and the RAM.
// slave = arbiter view, master = core/RAM environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_err;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_en, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_en, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational store lane formatting: byte strobes, data replication
// across lanes and the misalignment flag for a load/store request.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  assign o_wstrb    = strobe(i_size, i_addr_lo);
  assign o_misalign = misaligned(i_size, i_addr_lo);

  // Replicate right-justified store data so every enabled lane sees it.
  always_comb begin
    o_wdata = i_wdata;
    case (i_size)
      SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
      SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between fetch and load/store.
// Load/store has priority; read data is steered back by an owner register.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT
// consecutive load/store grants while fetch waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
);

  logic              w_force_if;
  logic              w_ls_win;
  logic              w_if_win;
  logic              w_misalign;
  logic [3:0]        w_strb;
  logic [DATA_W-1:0] w_wdata_rep;
  owner_e            w_owner_next;
  logic              w_err_next;
  owner_e            r_owner;
  logic              r_err;
  logic [DATA_W-1:0] r_if_hold;
  logic [DATA_W-1:0] r_ls_hold;
  logic              w_unused_if_lo;

  // Fetch addresses are word aligned; the low bits carry no information.
  assign w_unused_if_lo = ^bus.if_addr[1:0];

  mem_lane_align u_align (
    .i_size     (bus.ls_size),
    .i_addr_lo  (bus.ls_addr[1:0]),
    .i_wdata    (bus.ls_wdata),
    .o_wstrb    (w_strb),
    .o_wdata    (w_wdata_rep),
    .o_misalign (w_misalign)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] r_starve_cnt;

  assign w_force_if = bus.if_req & (r_starve_cnt == STARVE_W'(STARVE_LIMIT));

  // Count load/store grants that keep a pending fetch waiting; saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!bus.if_req || w_if_win) begin
      r_starve_cnt <= '0;
    end else if (w_ls_win && (r_starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  // Strict priority: the limit only matters when the guard is built.
  assign w_force_if = 1'b0 & (STARVE_LIMIT != 0);
`endif

  // Per-cycle arbitration: at most one winner, load/store first.
  always_comb begin
    w_ls_win = bus.ls_req & ~w_force_if;
    w_if_win = bus.if_req & ~w_ls_win;
  end

  assign bus.ls_gnt    = w_ls_win;
  assign bus.if_gnt    = w_if_win;
  assign bus.mem_en    = w_if_win | (w_ls_win & ~w_misalign);
  assign bus.mem_addr  = w_ls_win ? {bus.ls_addr[ADDR_W-1:2], 2'b00}
                                  : {bus.if_addr[ADDR_W-1:2], 2'b00};
  assign bus.mem_wstrb = (w_ls_win & bus.ls_we & ~w_misalign) ? w_strb : 4'b0000;
  assign bus.mem_wdata = w_wdata_rep;

  // Decide who owns next cycle's response; misaligned requests get an error response.
  always_comb begin
    w_owner_next = OWN_NONE;
    w_err_next   = 1'b0;
    if (w_ls_win) begin
      if (w_misalign) begin
        w_owner_next = OWN_LS;
        w_err_next   = 1'b1;
      end else if (!bus.ls_we) begin
        w_owner_next = OWN_LS;
      end
    end else if (w_if_win) begin
      w_owner_next = OWN_IF;
    end
  end

  // Response pipeline register; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
    end else begin
      r_owner <= w_owner_next;
      r_err   <= w_err_next;
    end
  end

  // Remember the last delivered word so rdata holds while rvalid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_hold <= '0;
      r_ls_hold <= '0;
    end else begin
      if (r_owner == OWN_IF) r_if_hold <= bus.mem_rdata;
      if (r_owner == OWN_LS) r_ls_hold <= r_err ? '0 : bus.mem_rdata;
    end
  end

  assign bus.if_rvalid = (r_owner == OWN_IF);
  assign bus.if_rdata  = (r_owner == OWN_IF) ? bus.mem_rdata : r_if_hold;
  assign bus.ls_rvalid = (r_owner == OWN_LS);
  assign bus.ls_err    = r_err;
  assign bus.ls_rdata  = (r_owner == OWN_LS) ? (r_err ? '0 : bus.mem_rdata) : r_ls_hold;

endmodule
